// File: rtl/serial_adder_ctrl.sv
// Serial adder: WIDTH-bit add over one 2-bit slice, LSB pair first; optional subtract under `SERIAL_ADDER_SUB_EN.
// Latency: start accepted at edge E0, done high in the cycle after edge E0+WIDTH/2.
// Backpressure: none queued; start is ignored while busy (RUN/DONE).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int NSL = WIDTH / 2;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [1:0]       sa;
    logic [1:0]       sb;
    logic [2:0]       sum;
    logic             last;

    // Slice mux, 2-bit adder and accumulator merge for the current count.
    always_comb begin
        sa      = '0;
        sb      = '0;
        acc_nxt = acc;
        for (int i = 0; i < NSL; i++) begin
            if (cnt == CW'(i)) begin
                sa = a_r[2*i +: 2];
                sb = b_r[2*i +: 2];
            end
        end
        sum = {1'b0, sa} + {1'b0, sb} + {2'b00, carry};
        for (int i = 0; i < NSL; i++) begin
            if (cnt == CW'(i)) begin
                acc_nxt[2*i +: 2] = sum[1:0];
            end
        end
        last = (cnt == CW'(NSL - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r <= a;
`ifdef SERIAL_ADDER_SUB_EN
                        // Subtract as a + ~b + 1: invert b once here, seed carry with 1.
                        b_r   <= op ? ~b : b;
                        carry <= op;
`else
                        b_r   <= b;
                        carry <= 1'b0;
`endif
                        cnt   <= '0;
                        acc   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_nxt;
                    carry <= sum[2];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        result    <= acc_nxt;
                        carry_out <= sum[2];
                        state     <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN) || (state == S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 directed vectors and a WIDTH=2 exhaustive sweep.
module tb_serial_adder_ctrl;

    typedef struct {
        logic [7:0] res;
        logic       c;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, start2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    logic       op;
    logic       busy8, done8, carry8;
    logic [7:0] result8;
    logic       busy2, done2, carry2;
    logic [1:0] result2;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q8[$];
    exp_t q2[$];

    logic [2:0] sum2_tab [16] = '{3'd0, 3'd1, 3'd2, 3'd3,
                                  3'd1, 3'd2, 3'd3, 3'd4,
                                  3'd2, 3'd3, 3'd4, 3'd5,
                                  3'd3, 3'd4, 3'd5, 3'd6};

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_ADDER_SUB_EN
        .op(op),
`endif
        .busy(busy8), .done(done8), .result(result8), .carry_out(carry8)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2),
`ifdef SERIAL_ADDER_SUB_EN
        .op(1'b0),
`endif
        .busy(busy2), .done(done2), .result(result2), .carry_out(carry2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("spurious_done8", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check("result8", 32'(result8), 32'(e.res));
                check("carry8", 32'(carry8), 32'(e.c));
                check("latency8", 32'(cyc), 32'(e.cyc));
            end
        end
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("spurious_done2", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("result2", 32'(result2), 32'(e.res));
                check("carry2", 32'(carry2), 32'(e.c));
                check("latency2", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge with dut8 idle; returns idle again.
    task automatic issue8(input logic [7:0] xa, input logic [7:0] xb, input logic xop,
                          input logic [7:0] er, input logic ec);
        a8 = xa; b8 = xb; op = xop; start8 = 1'b1;
        q8.push_back('{res: er, c: ec, cyc: cyc + 5});
        @(negedge clk);
        start8 = 1'b0;
        check("busy_after_accept", 32'(busy8), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic issue2(input logic [1:0] xa, input logic [1:0] xb, input logic [2:0] e);
        a2 = xa; b2 = xb; start2 = 1'b1;
        q2.push_back('{res: {6'd0, e[1:0]}, c: e[2], cyc: cyc + 2});
        @(negedge clk);
        start2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1; start8 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; a2 = '0; b2 = '0; op = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_result", 32'(result8), 32'h00);
        check("rst_carry", 32'(carry8), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        issue8(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
        check("result_holds", 32'(result8), 32'hFE);

        // start held high: three back-to-back ops, a disturbed mid-RUN of the first.
        n = cyc;
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        q8.push_back('{res: 8'h02, c: 1'b0, cyc: n + 5});
        q8.push_back('{res: 8'h02, c: 1'b0, cyc: n + 11});
        q8.push_back('{res: 8'h02, c: 1'b0, cyc: n + 17});
        repeat (2) @(negedge clk);
        a8 = 8'h10;
        repeat (2) @(negedge clk);
        a8 = 8'h01;
        repeat (9) @(negedge clk);
        start8 = 1'b0;
        repeat (8) @(negedge clk);
        check("held_queue_drained", 32'(q8.size()), 32'd0);

        // Reset during the second RUN cycle aborts with no done.
        a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_result", 32'(result8), 32'h00);
        check("abort_carry", 32'(carry8), 32'd0);
        repeat (6) @(negedge clk);
        check("abort_still_idle", 32'(busy8), 32'd0);
        issue8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        issue8(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
        issue8(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        issue8(8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

        for (int i = 0; i < 16; i++) begin
            issue2(2'(i >> 2), 2'(i), sum2_tab[i]);
        end

        for (int i = 0; i < 100 && (q8.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        check("q8_empty", 32'(q8.size()), 32'd0);
        check("q2_empty", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
